boot_mem_sequencer: RTL and testbench
=====================================

# boot_mem_sequencer

Sequences system bring-up around the instruction memory and owns its single port. After reset it holds the CPU in reset and grants the port to the UART boot loader. Once the loader reports completion, it waits a settle delay, then releases the CPU and hands the port to the CPU fetch path. It also supports a runtime reboot that re-arms the loader and reloads the image.

## Interface
- ADDR_W, 15, byte-address width of loader and CPU ports; memory word address is ADDR_W-2 bits
- DATA_W, 32, data width
- SETTLE_CYC, 16, cycles between loader done and CPU release (≥1)
- TIMEOUT_CYC, 2^24, idle-cycle limit in LOAD (used only with BOOT_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- boot_sel  in  1  strap: 1 = load image over UART, 0 = run resident image
- reboot_req  in  1  single-cycle pulse; honoured only in RUN
- ldr_rst_n  out  1  registered reset to loader, low only in LDR_RST
- ldr_boot_en  out  1  loader enable, high only in LOAD
- ldr_boot_done  in  1  loader sticky done flag
- ldr_we / ldr_waddr / ldr_wdata  in  1 / ADDR_W / DATA_W  loader write request
- cpu_re / cpu_addr  in  1 / ADDR_W  CPU fetch request
- cpu_rdata  out  DATA_W  fetch data
- cpu_rvalid  out  1  fetch data valid
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W-2 / DATA_W  memory port (combinational)
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency
- cpu_rst_n  out  1  registered CPU reset, high only in RUN
- boot_words  out  14  count of loader words written in the current LOAD
- ldr_err  out  1  sticky: loader write attempted outside LOAD

## Operation
- States: HOLD, LDR_RST, LOAD, SETTLE, RUN. Reset enters HOLD.
- HOLD (1 cycle): go to LOAD if boot_sel=1, otherwise SETTLE.
- LOAD: the loader owns the port. On ldr_we: mem_en=mem_we=1, mem_addr=ldr_waddr[ADDR_W-1:2], mem_wdata=ldr_wdata, and boot_words increments (saturating at 14'h3FFF). ldr_waddr[1:0] is ignored. On ldr_boot_done=1: go to SETTLE and load the settle counter with SETTLE_CYC-1. If ldr_we and ldr_boot_done occur in the same cycle, the write is performed, then the transition is taken.
- SETTLE: the counter decrements each cycle. At zero, go to RUN. The port is idle.
- RUN: the CPU owns the port. On cpu_re: mem_en=1, mem_we=0, mem_addr=cpu_addr[ADDR_W-1:2]. The next cycle, cpu_rvalid=1 and cpu_rdata=mem_rdata.
- reboot_req in RUN: go to LDR_RST. A fetch issued in that same cycle still completes; cpu_rvalid pulses one cycle later.
- LDR_RST (2 cycles, counted): ldr_rst_n=0, then go to LOAD. boot_words clears on LOAD entry.
- reboot_req outside RUN is ignored.
- ldr_we outside LOAD: no memory access, and ldr_err is set. cpu_re outside RUN: no memory access and no rvalid.
- boot_sel is sampled only in HOLD. A reboot always goes through LOAD, regardless of boot_sel.

## Timing
- Reset values: cpu_rst_n=0, ldr_rst_n=0, ldr_boot_en=0, cpu_rvalid=0, cpu_rdata=0, boot_words=0, ldr_err=0, state=HOLD.
- ldr_boot_en and mem_* are decoded from state. cpu_rst_n and ldr_rst_n are registered from next_state, so each changes in the same cycle the state changes.
- ldr_rst_n goes high on the first HOLD cycle after reset.
- Release latency: cpu_rst_n rises exactly SETTLE_CYC+1 cycles after the first cycle ldr_boot_done is sampled high in LOAD.
- Fetch latency: 1 cycle. There is no back-pressure: one request per cycle is accepted in RUN.
- Asserting rst_n mid-LOAD aborts immediately. Memory contents are not cleared.

## Configuration
- BOOT_TIMEOUT_EN defined: a 24-bit idle counter runs in LOAD. It clears on each ldr_we and on LOAD entry. If it reaches TIMEOUT_CYC, the block goes to SETTLE (a resident image runs) and sets a sticky output, boot_timeout.
- BOOT_TIMEOUT_EN undefined: LOAD waits indefinitely. The boot_timeout port exists and is tied to 0.

## Test plan
- boot_sel=1, loader writes 4 words to byte addresses 0,4,8,12 and then asserts done → mem_addr=0..3, boot_words=4, cpu_rst_n rises SETTLE_CYC+1 cycles after done.
- boot_sel=0 → no ldr_boot_en, cpu_rst_n rises SETTLE_CYC+1 cycles after HOLD.
- RUN, cpu_re at addr 0x0008 with mem_rdata=0xDEADBEEF → cpu_rvalid the next cycle, cpu_rdata=0xDEADBEEF, mem_addr=2.
- RUN, reboot_req with a same-cycle cpu_re → rvalid still pulses, cpu_rst_n falls, ldr_rst_n is low for 2 cycles, then LOAD with boot_words=0.
- ldr_we while in RUN → no mem_we, ldr_err=1 and stays set.
- BOOT_TIMEOUT_EN with TIMEOUT_CYC=100 and no loader writes → SETTLE entered after 100 cycles, boot_timeout=1.

Source files
------------

// File: rtl/boot_mem_sequencer.sv
// Boot sequencer owning the instruction-memory port: loader writes in LOAD, CPU fetches (1-cycle, no backpressure) in RUN.
// Define BOOT_TIMEOUT_EN to fall back to the resident image after TIMEOUT_CYC idle cycles in LOAD.
`timescale 1ns/1ps
module boot_mem_sequencer #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1 << 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_sel_i,
  input  logic              reboot_req_i,
  output logic              ldr_rst_n_o,
  output logic              ldr_boot_en_o,
  input  logic              ldr_boot_done_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_waddr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  input  logic              cpu_re_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_rst_n_o,
  output logic [13:0]       boot_words_o,
  output logic              ldr_err_o,
  output logic              boot_timeout_o
);

  typedef enum logic [2:0] {HOLD, LDR_RST, LOAD, SETTLE, RUN} state_e;

  localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [13:0]      words_q, words_d;
  logic             err_q, rvalid_q, cpu_rst_n_q, ldr_rst_n_q;
  logic             tmo_hit;
  logic             unused_ok;

  assign unused_ok = ^{ldr_waddr_i[1:0], cpu_addr_i[1:0]};

`ifdef BOOT_TIMEOUT_EN
  logic [23:0] idle_q;
  logic        tmo_q;

  assign tmo_hit = (state_q == LOAD) && !ldr_we_i &&
                   (({1'b0, idle_q} + 25'd1) == 25'(TIMEOUT_CYC));

  // Idle count is zero whenever outside LOAD, which also covers LOAD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= (state_q != LOAD || ldr_we_i) ? '0 : idle_q + 24'd1;
      if (tmo_hit && !ldr_boot_done_i) tmo_q <= 1'b1;
    end
  end
  assign boot_timeout_o = tmo_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo     = TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign boot_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (boot_sel_i) begin
          state_d = LOAD;
        end else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_INIT;
        end
      end
      LDR_RST: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      LOAD: begin
        if (ldr_boot_done_i || tmo_hit) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_INIT;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RUN: begin
        // Two LDR_RST cycles: counter loaded with 1, leaves at zero.
        if (reboot_req_i) begin
          state_d = LDR_RST;
          cnt_d   = CNT_W'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    words_d = words_q;
    if (state_q != LOAD && state_d == LOAD) begin
      words_d = '0;
    end else if (state_q == LOAD && ldr_we_i && words_q != 14'h3FFF) begin
      words_d = words_q + 14'd1;
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == LOAD) begin
      mem_en_o    = ldr_we_i;
      mem_we_o    = ldr_we_i;
      mem_addr_o  = ldr_waddr_i[ADDR_W-1:2];
      mem_wdata_o = ldr_wdata_i;
    end else if (state_q == RUN) begin
      mem_en_o   = cpu_re_i;
      mem_addr_o = cpu_addr_i[ADDR_W-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      ldr_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      err_q       <= err_q | (ldr_we_i && state_q != LOAD);
      rvalid_q    <= (state_q == RUN) && cpu_re_i;
      cpu_rst_n_q <= (state_d == RUN);
      ldr_rst_n_q <= (state_d != LDR_RST);
    end
  end

  // Memory read data arrives one cycle after the request, aligned with rvalid.
  assign cpu_rdata_o   = rvalid_q ? mem_rdata_i : '0;
  assign cpu_rvalid_o  = rvalid_q;
  assign cpu_rst_n_o   = cpu_rst_n_q;
  assign ldr_rst_n_o   = ldr_rst_n_q;
  assign ldr_boot_en_o = (state_q == LOAD);
  assign boot_words_o  = words_q;
  assign ldr_err_o     = err_q;

endmodule

// File: tb/tb_boot_mem_sequencer.sv
// Scoreboard bench for boot_mem_sequencer: stimulus queues expected port activity, a negedge monitor checks it.
`timescale 1ns/1ps
module tb_boot_mem_sequencer;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int S      = 6;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              boot_sel = 1'b0, reboot_req = 1'b0;
  logic              ldr_rst_n, ldr_boot_en, ldr_boot_done = 1'b0, ldr_we = 1'b0;
  logic [ADDR_W-1:0] ldr_waddr = '0, cpu_addr = '0;
  logic [DATA_W-1:0] ldr_wdata = '0, cpu_rdata, mem_wdata, mem_rdata;
  logic              cpu_re = 1'b0, cpu_rvalid, mem_en, mem_we, cpu_rst_n, ldr_err, boot_timeout;
  logic [ADDR_W-3:0] mem_addr;
  logic [13:0]       boot_words;

  always #5 clk = ~clk;

  boot_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYC(S), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .boot_sel_i(boot_sel), .reboot_req_i(reboot_req),
    .ldr_rst_n_o(ldr_rst_n), .ldr_boot_en_o(ldr_boot_en), .ldr_boot_done_i(ldr_boot_done),
    .ldr_we_i(ldr_we), .ldr_waddr_i(ldr_waddr), .ldr_wdata_i(ldr_wdata),
    .cpu_re_i(cpu_re), .cpu_addr_i(cpu_addr), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .cpu_rst_n_o(cpu_rst_n), .boot_words_o(boot_words),
    .ldr_err_o(ldr_err), .boot_timeout_o(boot_timeout)
  );

  // Single-port memory with 1-cycle read latency.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed { logic [12:0] a; logic [31:0] d; } wr_t;
  wr_t         wr_q[$];
  logic [12:0] ra_q[$];
  logic [31:0] rd_q[$];
  int          rel_q[$];
  int          lr_q[$];
  logic [31:0] ref_mem [0:8191];
  int          n_chk = 0, n_fail = 0, cyc, exp_words;
  logic        saw_en;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin : monitor
    logic prev_cpu, prev_lr, lr_on;
    int   lr_len;
    prev_cpu = 1'b0; prev_lr = 1'b0; lr_on = 1'b0; lr_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cpu = 1'b0; prev_lr = 1'b0; lr_on = 1'b0; lr_len = 0;
      end else begin
        if (ldr_boot_en) saw_en = 1'b1;
        if (mem_en && mem_we) begin
          chk("write_pending", 64'(wr_q.size() > 0), 1);
          if (wr_q.size() > 0) chk("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
        end
        if (mem_en && !mem_we) begin
          chk("read_pending", 64'(ra_q.size() > 0), 1);
          if (ra_q.size() > 0) chk("mem_read_addr", mem_addr, ra_q.pop_front());
        end
        if (cpu_rvalid) begin
          chk("rvalid_pending", 64'(rd_q.size() > 0), 1);
          if (rd_q.size() > 0) chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
        end
        if (cpu_rst_n && !prev_cpu) begin
          chk("release_pending", 64'(rel_q.size() > 0), 1);
          if (rel_q.size() > 0) chk("release_cycle", cyc, rel_q.pop_front());
        end
        if (!ldr_rst_n && prev_lr) begin lr_on = 1'b1; lr_len = 0; end
        if (lr_on && !ldr_rst_n) lr_len++;
        if (lr_on && ldr_rst_n) begin
          lr_on = 1'b0;
          chk("ldr_rst_pending", 64'(lr_q.size() > 0), 1);
          if (lr_q.size() > 0) chk("ldr_rst_len", lr_len, lr_q.pop_front());
        end
        prev_cpu = cpu_rst_n;
        prev_lr  = ldr_rst_n;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_en(input int budget);
    for (int i = 0; i < budget && !ldr_boot_en; i++) tick();
    chk("wait_boot_en", ldr_boot_en, 1);
  endtask

  task automatic wait_run(input int budget);
    for (int i = 0; i < budget && !cpu_rst_n; i++) tick();
    chk("wait_cpu_release", cpu_rst_n, 1);
  endtask

  task automatic load_word(input logic [14:0] a, input logic [31:0] d, input logic done);
    ldr_we = 1'b1; ldr_waddr = a; ldr_wdata = d; ldr_boot_done = done;
    wr_q.push_back(wr_t'{a[14:2], d});
    ref_mem[a[14:2]] = d;
    exp_words++;
    if (done) rel_q.push_back(cyc + S + 1);
    tick();
    ldr_we = 1'b0; ldr_boot_done = 1'b0;
  endtask

  task automatic fetch(input logic [14:0] a);
    cpu_re = 1'b1; cpu_addr = a;
    ra_q.push_back(a[14:2]);
    rd_q.push_back(ref_mem[a[14:2]]);
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic stray_write();
    ldr_we = 1'b1; ldr_waddr = 15'($urandom); ldr_wdata = $urandom;
    tick();
    ldr_we = 1'b0;
  endtask

  logic [14:0] addrs[$];

  initial begin : stim
    logic [14:0] a;
    int n;
    saw_en = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end

    // Resident image boot
    tick(); tick();
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_ldr_rst_n", ldr_rst_n, 0);
    chk("rst_boot_en", ldr_boot_en, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_words", boot_words, 0);
    chk("rst_err", ldr_err, 0);
    chk("rst_timeout", boot_timeout, 0);
    rel_q.push_back(S + 1);
    saw_en = 1'b0;
    rst_n = 1'b1;
    wait_run(50);
    chk("resident_no_boot_en", saw_en, 0);
    chk("ldr_rst_n_high", ldr_rst_n, 1);
    for (int i = 0; i < 8; i++) fetch(15'($urandom_range(0, 1023)));
    stray_write();
    chk("ldr_err_set", ldr_err, 1);

    // UART boot, aborted by reset mid-LOAD
    rst_n = 1'b0; boot_sel = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_en(10);
    exp_words = 0;
    chk("load_err_cleared", ldr_err, 0);
    load_word(15'h0100, 32'h1111_2222, 1'b0);
    ldr_we = 1'b1; ldr_waddr = 15'h0104; ldr_wdata = 32'h3333_4444;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_boot_en", ldr_boot_en, 0);
    chk("abort_mem_we", mem_we, 0);
    ldr_we = 1'b0;
    tick();
    rst_n = 1'b1;

    // UART boot, full
    wait_en(10);
    exp_words = 0;
    chk("load_words_zero", boot_words, 0);
    cpu_re = 1'b1; cpu_addr = 15'h0010;
    tick();
    cpu_re = 1'b0; reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0;
    chk("reboot_ignored_in_load", ldr_boot_en, 1);
    load_word(15'd0, 32'h0BAD_F00D, 1'b0);
    load_word(15'd4, 32'h1234_5678, 1'b0);
    load_word(15'd8, 32'hDEAD_BEEF, 1'b0);
    load_word(15'd12, 32'hCAFE_0001, 1'b0);
    chk("boot_words_4", boot_words, 4);
    for (int i = 0; i < 20; i++) begin
      a = {13'($urandom_range(16, 200)), 2'($urandom)};
      addrs.push_back(a);
      load_word(a, $urandom, 1'b0);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    chk("boot_words_rand", boot_words, exp_words);
    load_word(15'h0400, 32'hF1F2_F3F4, 1'b1);
    chk("boot_words_final", boot_words, exp_words);
    chk("settle_boot_en_low", ldr_boot_en, 0);
    wait_run(40);
    fetch(15'h0008);
    for (int i = 0; i < 10; i++) fetch(addrs[$urandom_range(0, addrs.size() - 1)]);

    // Reboot with a same-cycle fetch; boot_sel low must not skip LOAD
    boot_sel = 1'b0;
    lr_q.push_back(2);
    reboot_req = 1'b1;
    fetch(15'h0004);
    reboot_req = 1'b0;
    chk("reboot_cpu_rst_n", cpu_rst_n, 0);
    wait_en(10);
    exp_words = 0;
    chk("reboot_words_zero", boot_words, 0);
    load_word(15'h0020, 32'hAAAA_0001, 1'b0);
    load_word(15'h0025, 32'hAAAA_0002, 1'b0);
    tick();
    load_word(15'h002B, 32'hAAAA_0003, 1'b1);
    chk("reboot_words", boot_words, 3);
    wait_run(40);
    fetch(15'h0020); fetch(15'h0024); fetch(15'h0028); fetch(15'h0008);
    stray_write();
    tick(); tick();
    chk("ldr_err_sticky", ldr_err, 1);
    fetch(15'h0000);

`ifdef BOOT_TIMEOUT_EN
    rst_n = 1'b0; boot_sel = 1'b1;
    tick();
    rel_q.push_back(TMO + S + 1);
    rst_n = 1'b1;
    wait_en(10);
    n = 0;
    while (ldr_boot_en && n < 3 * TMO) begin n++; tick(); end
    chk("timeout_load_cycles", n, TMO);
    chk("boot_timeout_set", boot_timeout, 1);
    wait_run(50);
    chk("timeout_sticky", boot_timeout, 1);
`else
    n = 0;
    chk("boot_timeout_tied", boot_timeout, 0);
`endif

    tick(); tick(); tick();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("ra_q_drained", ra_q.size(), 0);
    chk("rel_q_drained", rel_q.size(), 0);
    chk("lr_q_drained", lr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
